// File: rtl/led_ctrl_if.sv
// led_ctrl_if: frame request, colour inputs and serial LED outputs.
// master drives requests and colours; slave is the controller.
interface led_ctrl_if;
  logic        start;
  logic        en;
  logic [31:0] mean_r;
  logic [31:0] mean_g;
  logic [31:0] mean_b;
  logic        cko_o;
  logic [7:0]  sdo;
  logic        lat_o;
  logic        busy_o;
  logic        fifo_empty_o;

  modport master (
    output start, en, mean_r, mean_g, mean_b,
    input  cko_o, sdo, lat_o, busy_o, fifo_empty_o
  );

  modport slave (
    input  start, en, mean_r, mean_g, mean_b,
    output cko_o, sdo, lat_o, busy_o, fifo_empty_o
  );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: 8-lane LED frame controller (snapshot -> FIFO -> shift).
// Optional macro LED_CTRL_PARITY_EN appends an even-parity bit per lane.
module led_ctrl #(
  parameter int CKO_DIV    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input logic     clk,
  input logic     rst,
  led_ctrl_if.slave bus
);

`ifdef LED_CTRL_PARITY_EN
  localparam int LW = 13;
`else
  localparam int LW = 12;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(2 * CKO_DIV + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [31:0]   r_snap_r;
  logic [31:0]   r_snap_g;
  logic [31:0]   r_snap_b;
  logic          r_wr_active;
  logic [2:0]    r_wr_idx;

  logic [11:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [1:0]    r_state;
  logic [3:0]    r_step;
  logic [DW-1:0] r_div;
  logic [7:0][LW-1:0] r_lane;
  logic          r_cko;
  logic [7:0]    r_sdo;
  logic          r_lat;

  logic          w_empty;
  logic          w_en_ok;
  logic          w_start_ok;
  logic          w_rd;
  logic [11:0]   w_word;
  logic [11:0]   w_rd_data;
  logic [LW-1:0] w_ld;
  logic [7:0]    w_msb;
  logic          w_period_end;
  logic          w_half;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_en_ok    = bus.en && (r_state == S_IDLE) &&
                      (r_count == CW'(8)) && !r_wr_active;
  // An accepted en implies a full FIFO, so start is also masked then.
  assign w_start_ok = bus.start && w_empty && !r_wr_active && !w_en_ok;
  assign w_rd       = (r_state == S_DRAIN) && (r_step != 4'd8);

  assign w_word = {r_snap_r[{r_wr_idx, 2'b00} +: 4],
                   r_snap_g[{r_wr_idx, 2'b00} +: 4],
                   r_snap_b[{r_wr_idx, 2'b00} +: 4]};

  assign w_rd_data = r_mem[r_rptr];
`ifdef LED_CTRL_PARITY_EN
  assign w_ld = {w_rd_data, ^w_rd_data};
`else
  assign w_ld = w_rd_data;
`endif

  assign w_period_end = (r_div == DW'(2 * CKO_DIV - 1));
  assign w_half       = (r_div == DW'(CKO_DIV - 1));

  // Current MSB of every lane: the bit presented at the next boundary.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 8; i++) begin
      w_msb[i] = r_lane[i][LW-1];
    end
  end

  // Writer: snapshot colours on start, then push words 0..7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_r    <= '0;
      r_snap_g    <= '0;
      r_snap_b    <= '0;
      r_wr_active <= 1'b0;
      r_wr_idx    <= '0;
    end else if (w_start_ok) begin
      r_snap_r    <= bus.mean_r;
      r_snap_g    <= bus.mean_g;
      r_snap_b    <= bus.mean_b;
      r_wr_active <= 1'b1;
      r_wr_idx    <= '0;
    end else if (r_wr_active) begin
      r_wr_idx <= r_wr_idx + 3'd1;
      if (r_wr_idx == 3'd7) begin
        r_wr_active <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (r_wr_active) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_wr_active) begin
        r_wptr <= inc_ptr(r_wptr);
      end
      if (w_rd) begin
        r_rptr <= inc_ptr(r_rptr);
      end
      if (r_wr_active && !w_rd) begin
        r_count <= r_count + CW'(1);
      end else if (!r_wr_active && w_rd) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sender FSM: drain into lanes, shift MSB first, then latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_div   <= '0;
      r_lane  <= '0;
      r_cko   <= 1'b0;
      r_sdo   <= '0;
      r_lat   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_en_ok) begin
            r_state <= S_DRAIN;
            r_step  <= '0;
          end
        end
        S_DRAIN: begin
          if (r_step == 4'd8) begin
            r_state <= S_SHIFT;
            r_step  <= '0;
            r_div   <= '0;
            r_cko   <= 1'b0;
            r_sdo   <= w_msb;
            for (int i = 0; i < 8; i++) begin
              r_lane[i] <= {r_lane[i][LW-2:0], 1'b0};
            end
          end else begin
            r_lane[r_step[2:0]] <= w_ld;
            r_step <= r_step + 4'd1;
          end
        end
        S_SHIFT: begin
          if (w_period_end) begin
            r_div <= '0;
            r_cko <= 1'b0;
            if (r_step == 4'(LW - 1)) begin
              r_state <= S_LATCH;
              r_sdo   <= '0;
              r_lat   <= 1'b1;
            end else begin
              r_step <= r_step + 4'd1;
              r_sdo  <= w_msb;
              for (int i = 0; i < 8; i++) begin
                r_lane[i] <= {r_lane[i][LW-2:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + DW'(1);
            if (w_half) begin
              r_cko <= 1'b1;
            end
          end
        end
        S_LATCH: begin
          if (w_period_end) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_lat   <= 1'b0;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cko_o        = r_cko;
  assign bus.sdo          = r_sdo;
  assign bus.lat_o        = r_lat;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.fifo_empty_o = w_empty;

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed frames with a per-bit sdo scoreboard.
// Build with LED_CTRL_PARITY_EN to expect the 13th parity bit.
module tb_led_ctrl;
  localparam int CKO_DIV = 5;
`ifdef LED_CTRL_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int FRAME_LEN = 9 + (NB + 1) * 2 * CKO_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_ctrl_if bus ();

  led_ctrl #(.CKO_DIV(CKO_DIV), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] cap[$];
  int edges = 0;
  int lat_cyc = 0;
  logic prev_cko = 1'b0;
  logic [31:0] rr, rg, rb;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected sdo byte for each bit period of a frame.
  function automatic void push_frame(input logic [31:0] r,
                                     input logic [31:0] g,
                                     input logic [31:0] b);
    logic [7:0]  e;
    logic [11:0] w;
    for (int k = 0; k < NB; k++) begin
      e = '0;
      for (int i = 0; i < 8; i++) begin
        w = {r[4*i +: 4], g[4*i +: 4], b[4*i +: 4]};
        e[i] = (k < 12) ? w[11-k] : ^w;
      end
      sb.push_back(e);
    end
  endfunction

  // Sample on the falling edge: score sdo at each cko rising edge.
  always @(negedge clk) begin
    if (bus.cko_o && !prev_cko) begin
      edges++;
      cap.push_back(bus.sdo);
      check("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) check("sdo_bit", bus.sdo, sb.pop_front());
    end
    if (bus.lat_o) begin
      lat_cyc++;
      check("sdo_in_latch", bus.sdo, 0);
    end
    prev_cko = bus.cko_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] r, input logic [31:0] g,
                             input logic [31:0] b);
    @(negedge clk);
    bus.mean_r = r;
    bus.mean_g = g;
    bus.mean_b = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_en();
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  // start_at: 0 none, 1 same cycle as en, 2 during DRAIN.
  task automatic send_frame(input string tag, input int start_at);
    int cyc;
    edges   = 0;
    lat_cyc = 0;
    cap.delete();
    @(negedge clk);
    bus.en    = 1'b1;
    bus.start = (start_at == 1);
    @(posedge clk);
    #1;
    bus.en    = 1'b0;
    bus.start = (start_at == 2);
    check({tag, "_busy_rise"}, bus.busy_o, 1);
    cyc = 0;
    while (bus.busy_o && cyc < 400) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end
    check({tag, "_len"}, cyc, FRAME_LEN);
    check({tag, "_edges"}, edges, NB);
    check({tag, "_lat_cyc"}, lat_cyc, 2 * CKO_DIV);
    check({tag, "_sb_drained"}, sb.size(), 0);
    check({tag, "_lat_low"}, bus.lat_o, 0);
    check({tag, "_empty"}, bus.fifo_empty_o, 1);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.en     = 1'b0;
    bus.mean_r = '0;
    bus.mean_g = '0;
    bus.mean_b = '0;

    // Reset state
    repeat (3) tick();
    check("rst_cko", bus.cko_o, 0);
    check("rst_sdo", bus.sdo, 0);
    check("rst_lat", bus.lat_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_empty", bus.fifo_empty_o, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // en with empty FIFO is ignored
    edges = 0;
    pulse_en();
    check("ign_en_busy", bus.busy_o, 0);
    repeat (30) tick();
    check("ign_en_busy_late", bus.busy_o, 0);
    check("ign_en_edges", edges, 0);

    // Basic frame: element i = i+1
    drive_start(32'h87654321, 32'h87654321, 32'h87654321);
    check("wr_empty_T", bus.fifo_empty_o, 1);
    tick();
    check("wr_empty_T1", bus.fifo_empty_o, 0);
    bus.mean_r = 32'hFFFF_FFFF;
    bus.mean_g = 32'h0;
    bus.mean_b = 32'hA5A5_A5A5;
    pulse_en();
    check("early_en_busy", bus.busy_o, 0);
    repeat (10) tick();
    push_frame(32'h87654321, 32'h87654321, 32'h87654321);
    send_frame("basic", 0);
    check("basic_ncap", cap.size(), NB);
    if (cap.size() >= 12) begin
      check("basic_b0", cap[0], 8'h80);
      check("basic_b1", cap[1], 8'h78);
      check("basic_b2", cap[2], 8'h66);
      check("basic_b3", cap[3], 8'h55);
      check("basic_g0", cap[4], 8'h80);
      check("basic_bb3", cap[11], 8'h55);
`ifdef LED_CTRL_PARITY_EN
      check("parity_lane0", cap[12][0], 1);
`endif
    end

    // Random frame; extra starts while busy or full are ignored
    rr = $urandom();
    rg = $urandom();
    rb = $urandom();
    drive_start(rr, rg, rb);
    drive_start(~rr, ~rg, ~rb);
    repeat (10) tick();
    drive_start(rg, rb, rr);
    tick();
    push_frame(rr, rg, rb);
    send_frame("drain_start", 2);
    repeat (12) tick();
    check("drain_start_empty", bus.fifo_empty_o, 1);

    // start in the same cycle as an accepted en
    rr = $urandom();
    rg = $urandom();
    rb = $urandom();
    drive_start(rr, rg, rb);
    repeat (10) tick();
    push_frame(rr, rg, rb);
    send_frame("simul", 1);
    repeat (12) tick();
    check("simul_empty", bus.fifo_empty_o, 1);

    // Reset mid-SHIFT
    drive_start(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
    repeat (10) tick();
    push_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
    pulse_en();
    repeat (40) tick();
    check("pre_rst_busy", bus.busy_o, 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_cko", bus.cko_o, 0);
    check("mid_rst_sdo", bus.sdo, 0);
    check("mid_rst_lat", bus.lat_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_empty", bus.fifo_empty_o, 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    tick();
    pulse_en();
    repeat (30) tick();
    check("post_rst_busy", bus.busy_o, 0);
    check("post_rst_edges", edges, 0);
    check("post_rst_empty", bus.fifo_empty_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
